qdma_master: RTL and testbench

QDMA_MASTER -- requirements
Module: qdma_master

---
 rtl/qdma_master.sv | 213 +++++++++++++++++++++
 tb/tb_qdma_master.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qdma_master.sv
// QBUS DMA master: arbitrates for the bus and runs one DATI or DATO(B) cycle per request.
// Define QDMA_TIMEOUT_EN to add a data-phase RRPLY timeout that reports through err.
module qdma_master #(
    parameter int SETUP_CYC   = 16,
    parameter int HOLD_CYC    = 12,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        req_write,
    input  logic        req_byte,
    input  logic [21:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        busy,
    output logic        ack,
    output logic [15:0] rdata,
    output logic        err,
    output logic        TDMR,
    input  logic        RDMG,
    output logic        TSACK,
    input  logic        RSYNC,
    input  logic        RRPLY,
    output logic        TSYNC,
    output logic        TDIN,
    output logic        TDOUT,
    output logic        TWTBT,
    output logic        TBS7,
    output logic        DALtx,
    inout  wire  [21:0] DAL
);
    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_GRANT, S_ADDR,
        S_HOLD, S_DSETUP, S_DATA, S_END
    } state_t;

    localparam int CW = 16;
    localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);
`ifdef QDMA_TIMEOUT_EN
    localparam logic [CW-1:0] TMO_LAST   = CW'(TIMEOUT_CYC - 1);
`endif

    state_t        state;
    logic [CW-1:0] cnt;
    logic          write_q;
    logic          byte_q;
    logic [21:0]   addr_q;
    logic [15:0]   wdata_q;
    logic [21:0]   dal_q;
    logic [1:0]    rdmg_ff;
    logic [1:0]    rsync_ff;
    logic [1:0]    rrply_ff;
    logic          rdmg_s;
    logic          rsync_s;
    logic          rrply_s;
    logic          unused_dal_hi;

    assign rdmg_s  = rdmg_ff[1];
    assign rsync_s = rsync_ff[1];
    assign rrply_s = rrply_ff[1];

    // DAL is released whenever the driver-enable register is low
    assign DAL = DALtx ? dal_q : 'z;
    assign unused_dal_hi = ^DAL[21:16];

`ifndef QDMA_TIMEOUT_EN
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            write_q  <= 1'b0;
            byte_q   <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            dal_q    <= '0;
            rdmg_ff  <= '0;
            rsync_ff <= '0;
            rrply_ff <= '0;
            busy     <= 1'b0;
            ack      <= 1'b0;
            rdata    <= '0;
            TDMR     <= 1'b0;
            TSACK    <= 1'b0;
            TSYNC    <= 1'b0;
            TDIN     <= 1'b0;
            TDOUT    <= 1'b0;
            TWTBT    <= 1'b0;
            TBS7     <= 1'b0;
            DALtx    <= 1'b0;
`ifdef QDMA_TIMEOUT_EN
            err      <= 1'b0;
`endif
        end else begin
            rdmg_ff  <= {rdmg_ff[0], RDMG};
            rsync_ff <= {rsync_ff[0], RSYNC};
            rrply_ff <= {rrply_ff[0], RRPLY};
            ack      <= 1'b0;
`ifdef QDMA_TIMEOUT_EN
            err      <= 1'b0;
`endif
            unique case (state)
                S_IDLE: begin
                    if (req) begin
                        write_q <= req_write;
                        byte_q  <= req_byte;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        busy    <= 1'b1;
                        TDMR    <= 1'b1;
                        state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (rdmg_s) begin
                        TSACK <= 1'b1;
                        TDMR  <= 1'b0;
                        state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    // wait for the previous master to finish its cycle
                    if (!rsync_s && !rrply_s) begin
                        dal_q <= addr_q;
                        DALtx <= 1'b1;
                        TBS7  <= &addr_q[21:13];
                        TWTBT <= write_q;
                        cnt   <= '0;
                        state <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (cnt == SETUP_LAST) begin
                        TSYNC <= 1'b1;
                        cnt   <= '0;
                        state <= S_HOLD;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        if (write_q) begin
                            dal_q <= {6'b0, wdata_q};
                            TWTBT <= byte_q;
                        end else begin
                            DALtx <= 1'b0;
                            TWTBT <= 1'b0;
                            TBS7  <= 1'b0;
                        end
                        cnt   <= '0;
                        state <= S_DSETUP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DSETUP: begin
                    if (!write_q) begin
                        TDIN  <= 1'b1;
                        cnt   <= '0;
                        state <= S_DATA;
                    end else if (cnt == SETUP_LAST) begin
                        TDOUT <= 1'b1;
                        cnt   <= '0;
                        state <= S_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (rrply_s) begin
                        if (!write_q) rdata <= DAL[15:0];
                        TDIN  <= 1'b0;
                        TDOUT <= 1'b0;
                        state <= S_END;
                    end
`ifdef QDMA_TIMEOUT_EN
                    else if (cnt == TMO_LAST) begin
                        TDIN  <= 1'b0;
                        TDOUT <= 1'b0;
                        TSYNC <= 1'b0;
                        TSACK <= 1'b0;
                        TWTBT <= 1'b0;
                        TBS7  <= 1'b0;
                        DALtx <= 1'b0;
                        busy  <= 1'b0;
                        err   <= 1'b1;
                        cnt   <= '0;
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
`endif
                end
                S_END: begin
                    if (!rrply_s) begin
                        TSYNC <= 1'b0;
                        TSACK <= 1'b0;
                        TWTBT <= 1'b0;
                        TBS7  <= 1'b0;
                        DALtx <= 1'b0;
                        busy  <= 1'b0;
                        ack   <= 1'b1;
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_qdma_master.sv
// Randomized bench for qdma_master: a QBUS slave/arbiter model drives the bus
// and a queue of requested transactions supplies the expected bus behaviour.
module tb_qdma_master;
    localparam int SETUP = 4;
    localparam int HOLD  = 3;
    localparam int TMO   = 40;
    localparam int LIM   = 400;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req = 1'b0;
    logic        req_write = 1'b0;
    logic        req_byte = 1'b0;
    logic [21:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        busy, ack, err;
    logic [15:0] rdata;
    logic        TDMR, TSACK, TSYNC, TDIN, TDOUT, TWTBT, TBS7, DALtx;
    logic        RDMG = 1'b0;
    logic        RSYNC = 1'b0;
    logic        RRPLY = 1'b0;
    wire  [21:0] DAL;
    logic [21:0] tb_dal = '0;
    logic        tb_drv = 1'b0;

    assign DAL = tb_drv ? tb_dal : 'z;

    typedef struct {
        bit          w;
        bit          b;
        logic [21:0] a;
        logic [15:0] d;
    } txn_t;

    txn_t        q[$];
    logic [15:0] last_rd = '0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          acks = 0;
    int          rises = 0;
    int          clash = 0;
    logic        tsync_d = 1'b0;

    qdma_master #(
        .SETUP_CYC(SETUP), .HOLD_CYC(HOLD), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req(req),
        .req_write(req_write), .req_byte(req_byte),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .busy(busy), .ack(ack), .rdata(rdata), .err(err),
        .TDMR(TDMR), .RDMG(RDMG), .TSACK(TSACK),
        .RSYNC(RSYNC), .RRPLY(RRPLY), .TSYNC(TSYNC),
        .TDIN(TDIN), .TDOUT(TDOUT), .TWTBT(TWTBT),
        .TBS7(TBS7), .DALtx(DALtx), .DAL(DAL)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ack) acks++;
        if (TSYNC && !tsync_d) rises++;
        if (TDIN && DALtx) clash++;
        tsync_d = TSYNC;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic post(input bit w, input bit b, input logic [21:0] a,
                        input logic [15:0] d);
        txn_t t;
        t.w = w; t.b = b; t.a = a; t.d = d;
        q.push_back(t);
        req_write = w; req_byte = b; req_addr = a; req_wdata = d;
        req = 1'b1;
    endtask

    task automatic issue(input bit w, input bit b, input logic [21:0] a,
                         input logic [15:0] d);
        if (w && {6'b0, d} == a) d = ~d;
        post(w, b, a, d);
        tick();
        check("accept_busy", busy, 1);
        check("accept_tdmr", TDMR, 1);
        req = 1'b0;
    endtask

    // mode 0: normal, 1: reset during write data phase, 2: no reply
    task automatic serve(input int mode, input logic [15:0] rd);
        txn_t t;
        int   n;
        int   hs;
        int   a0;
        int   r0;
        bit   bad;
        t  = q.pop_front();
        a0 = acks;
        r0 = rises;
        hs = $urandom_range(0, 4);
        repeat ($urandom_range(0, 6)) tick();
        RDMG  = 1'b1;
        RSYNC = (hs != 0);
        n = 0;
        while (!TSACK && n < LIM) begin tick(); n++; end
        check("tsack", TSACK, 1);
        check("tdmr_off", TDMR, 0);
        RDMG = 1'b0;
        bad = 0;
        repeat (hs) begin tick(); if (TSYNC || DALtx) bad = 1; end
        RSYNC = 1'b0;
        check("rsync_block", bad, 0);
        n = 0;
        while (!DALtx && n < LIM) begin tick(); n++; end
        check("addr_dal", DAL, t.a);
        check("addr_tbs7", TBS7, (t.a >> 13) == 22'h1FF);
        check("addr_twtbt", TWTBT, t.w);
        n = 0; bad = 0;
        while (!TSYNC && n < LIM) begin
            if (DAL !== t.a || !DALtx) bad = 1;
            tick(); n++;
        end
        check("addr_setup", n, SETUP);
        check("addr_stable", bad, 0);
        n = 0;
        while (DALtx && DAL === t.a && n < LIM) begin tick(); n++; end
        check("addr_hold", n, HOLD);
        if (t.w) begin
            check("wr_dal", DAL, {6'b0, t.d});
            check("wr_twtbt", TWTBT, t.b);
            n = 0;
            while (!TDOUT && n < LIM) begin tick(); n++; end
            check("wr_setup", n, SETUP);
        end else begin
            check("rd_release", {DALtx, TWTBT, TBS7}, 0);
            n = 0;
            while (!TDIN && n < LIM) begin tick(); n++; end
            check("rd_setup", n, 1);
        end
        if (mode == 1) begin
            #2 reset_n = 1'b0;
            #1;
            check("rst_mid", {TDMR, TSACK, TSYNC, TDIN, TDOUT, TWTBT,
                              TBS7, DALtx, busy, ack, err}, 0);
            check("rst_mid_rdata", rdata, 0);
            last_rd = '0;
            @(negedge clk) reset_n = 1'b1;
            tick(); tick();
            check("rst_idle", {busy, TDMR}, 0);
            return;
        end
        if (mode == 2) begin
`ifdef QDMA_TIMEOUT_EN
            n = 0;
            while (!err && n < LIM) begin tick(); n++; end
            check("tmo_cycles", n, TMO);
            check("tmo_release", {TDIN, TDOUT, TSYNC, TSACK, TWTBT,
                                  DALtx, busy, ack}, 0);
            tick();
            check("tmo_pulse", err, 0);
            check("tmo_noack", acks - a0, 0);
            return;
`else
            repeat (3 * TMO) tick();
            check("no_tmo_wait", {TDIN, TSYNC, busy, err}, 4'b1110);
`endif
        end
        repeat ($urandom_range(0, 8)) tick();
        if (!t.w) begin
            tb_dal = {6'b0, rd};
            tb_drv = 1'b1;
        end
        RRPLY = 1'b1;
        n = 0;
        while ((TDIN || TDOUT) && n < LIM) begin tick(); n++; end
        check("strobe_off", TDIN | TDOUT, 0);
        check("tsync_held", TSYNC, 1);
        tb_drv = 1'b0;
        repeat ($urandom_range(0, 4)) tick();
        RRPLY = 1'b0;
        n = 0;
        while (!ack && n < LIM) begin tick(); n++; end
        check("ack", ack, 1);
        if (!t.w) last_rd = rd;
        check("rdata", rdata, last_rd);
        check("end_release", {busy, TSYNC, TSACK, TWTBT, DALtx,
                              TBS7, TDIN, TDOUT, err}, 0);
        check("one_tsync", rises - r0, 1);
        tick();
        check("ack_pulse", ack, 0);
        check("ack_count", acks - a0, 1);
    endtask

    initial begin
        logic [21:0] a;
        repeat (3) tick();
        check("rst_out", {busy, ack, err, TDMR, TSACK, TSYNC, TDIN,
                          TDOUT, TWTBT, TBS7, DALtx}, 0);
        check("rst_rdata", rdata, 0);
        @(negedge clk) reset_n = 1'b1;
        tick();
        check("idle_busy", busy, 0);

        issue(1'b0, 1'b0, 22'o17772520, 16'h0);
        serve(0, 16'h1234);
        issue(1'b1, 1'b0, 22'h001000, 16'hBEEF);
        serve(0, 16'h0);
        issue(1'b1, 1'b1, 22'h3FE001, 16'h00A5);
        serve(0, 16'h0);

        issue(1'b0, 1'b0, 22'h2AAAAA, 16'h0);
        post(1'b1, 1'b0, 22'h155555, 16'h5A5A);
        serve(0, 16'hC3C3);
        check("b2b_busy", busy, 1);
        check("b2b_tdmr", TDMR, 1);
        req = 1'b0;
        serve(0, 16'h0);

        for (int i = 0; i < 12; i++) begin
            a = 22'($urandom);
            if ($urandom_range(0, 3) == 0) a[21:13] = '1;
            issue(1'($urandom), 1'($urandom), a, 16'($urandom));
            serve(0, 16'($urandom));
        end

        issue(1'b0, 1'b0, 22'($urandom), 16'h0);
        serve(2, 16'h6E6E);
        issue(1'b1, 1'b0, 22'h0ABCDE, 16'h1357);
        serve(1, 16'h0);
        issue(1'b0, 1'b0, 22'h3FFFFF, 16'h0);
        serve(0, 16'h9ABC);

        check("no_dal_during_tdin", clash, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
